// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle control FSM: state codes, opcodes,
// datapath select vectors and the instruction class carried between states.
package ctrl_pkg;

    // State encodings (exposed on the state port)
    localparam logic [2:0] ST_FETCH     = 3'd0;
    localparam logic [2:0] ST_DECODE    = 3'd1;
    localparam logic [2:0] ST_EXECUTE   = 3'd2;
    localparam logic [2:0] ST_MEM       = 3'd3;
    localparam logic [2:0] ST_WRITEBACK = 3'd4;
    localparam logic [2:0] ST_TRAP      = 3'd5;

    // Opcodes (low three bits of the opcode field)
    localparam logic [2:0] OP_LW   = 3'd1;
    localparam logic [2:0] OP_SW   = 3'd2;
    localparam logic [2:0] OP_JUMP = 3'd3;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_ADDI = 3'd5;
    localparam logic [2:0] OP_SUB  = 3'd6;

    // Select vectors, bit order {alu, reg, imm, data, mux, jump}
    localparam int unsigned SEL_W = 6;
    localparam logic [SEL_W-1:0] SEL_NONE = 6'b000000;
    localparam logic [SEL_W-1:0] SEL_LW   = 6'b011010;
    localparam logic [SEL_W-1:0] SEL_SW   = 6'b001110;
    localparam logic [SEL_W-1:0] SEL_JUMP = 6'b000001;
    localparam logic [SEL_W-1:0] SEL_ADD  = 6'b010000;
    localparam logic [SEL_W-1:0] SEL_ADDI = 6'b011000;
    localparam logic [SEL_W-1:0] SEL_SUB  = 6'b110000;

    // Instruction class, decides the path after DECODE
    typedef enum logic [1:0] {OpLoad, OpStore, OpJump, OpAlu} op_class_e;

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode decode: select vector, instruction class and legality.
// Any opcode with bits above bit 2 set, or low bits 0/7, is undefined.
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 3
) (
    input  logic [OPCODE_W-1:0] opcode,
    output logic [SEL_W-1:0]    sel,
    output op_class_e           op_class,
    output logic                legal
);

    logic       upper_set;
    logic [2:0] low;

    assign low = opcode[2:0];

    if (OPCODE_W > 3) begin : g_upper
        assign upper_set = |opcode[OPCODE_W-1:3];
    end else begin : g_no_upper
        assign upper_set = 1'b0;
    end

    // Table lookup; undefined opcodes decode to all-zero selects
    always_comb begin
        sel      = SEL_NONE;
        op_class = OpAlu;
        legal    = 1'b0;
        if (!upper_set) begin
            case (low)
                OP_LW:   begin sel = SEL_LW;   op_class = OpLoad;  legal = 1'b1; end
                OP_SW:   begin sel = SEL_SW;   op_class = OpStore; legal = 1'b1; end
                OP_JUMP: begin sel = SEL_JUMP; op_class = OpJump;  legal = 1'b1; end
                OP_ADD:  begin sel = SEL_ADD;  op_class = OpAlu;   legal = 1'b1; end
                OP_ADDI: begin sel = SEL_ADDI; op_class = OpAlu;   legal = 1'b1; end
                OP_SUB:  begin sel = SEL_SUB;  op_class = OpAlu;   legal = 1'b1; end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mc_control_fsm.sv
// Multi-cycle processor control FSM with registered datapath selects,
// per-cycle strobes and a retired-instruction counter.
// Build option: CTRL_ILLEGAL_TRAP_EN makes undefined opcodes enter a sticky
// TRAP state; without it they retire as NOPs.
module mc_control_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned OPCODE_W = 3,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                aluSelect,
    output logic                regSelect,
    output logic                immSelect,
    output logic                dataSelect,
    output logic                muxSelect,
    output logic                jumpSelect,
    output logic                pc_write,
    output logic                ir_write,
    output logic                reg_write,
    output logic                mem_read,
    output logic                mem_write,
    output logic [2:0]          state,
    output logic [CNT_W-1:0]    retired,
    output logic                illegal
);

    if (OPCODE_W < 3) begin : g_bad_opcode_w
        $error("mc_control_fsm: OPCODE_W must be at least 3");
    end

    logic [2:0]       state_q, state_d;
    logic [SEL_W-1:0] sel_q;
    op_class_e        cls_q;
    logic [CNT_W-1:0] retired_q;
    logic             latch_sel;
    logic             retire_inc;

    logic [SEL_W-1:0] dec_sel;
    op_class_e        dec_cls;
    logic             dec_legal;

    ctrl_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .opcode   (opcode),
        .sel      (dec_sel),
        .op_class (dec_cls),
        .legal    (dec_legal)
    );

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
    logic set_illegal;
`endif

    // Next-state and strobe generation
    always_comb begin
        state_d    = state_q;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        latch_sel  = 1'b0;
        retire_inc = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        set_illegal = 1'b0;
`endif
        case (state_q)
            ST_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                latch_sel = 1'b1;
                if (!dec_legal) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    set_illegal = 1'b1;
                    state_d     = ST_TRAP;
`else
                    retire_inc = 1'b1;
                    state_d    = ST_FETCH;
`endif
                end else if (dec_cls == OpJump) begin
                    pc_write   = 1'b1;
                    retire_inc = 1'b1;
                    state_d    = ST_FETCH;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                state_d = (cls_q == OpLoad || cls_q == OpStore) ? ST_MEM : ST_WRITEBACK;
            end
            ST_MEM: begin
                if (cls_q == OpStore) mem_write = 1'b1;
                else                  mem_read  = 1'b1;
                if (mem_ready) begin
                    if (cls_q == OpStore) begin
                        retire_inc = 1'b1;
                        state_d    = ST_FETCH;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end
            end
            ST_WRITEBACK: begin
                reg_write  = 1'b1;
                retire_inc = 1'b1;
                state_d    = ST_FETCH;
            end
`ifdef CTRL_ILLEGAL_TRAP_EN
            ST_TRAP: state_d = ST_TRAP;
`endif
            default: state_d = ST_FETCH;
        endcase
        // A reset cycle abandons the instruction, so no side effects leak out
        if (reset) begin
            pc_write  = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
        end
    end

    // State, select, and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            sel_q     <= SEL_NONE;
            cls_q     <= OpAlu;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_sel) begin
                sel_q <= dec_sel;
                cls_q <= dec_cls;
            end
            if (retire_inc) retired_q <= retired_q + CNT_W'(1);
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    // Sticky illegal-opcode flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset)            illegal_q <= 1'b0;
        else if (set_illegal) illegal_q <= 1'b1;
    end
    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign {aluSelect, regSelect, immSelect, dataSelect, muxSelect, jumpSelect} = sel_q;
    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: doc/mc_control_fsm.md
MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter OPCODE_W, default 3, opcode field width; values below 3 SHALL be rejected at elaboration.
REQ-002 Parameter CNT_W, default 16, width of the retired-instruction counter.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port opcode, input, OPCODE_W: opcode from the instruction register, sampled only in DECODE.
REQ-006 Port mem_ready, input, 1: memory handshake; a transfer completes on any cycle where mem_read or mem_write is high and mem_ready is high.
REQ-007 Ports aluSelect, regSelect, immSelect, dataSelect, muxSelect, jumpSelect, output, 1 each: registered datapath selects.
REQ-008 Ports pc_write, ir_write, reg_write, mem_read, mem_write, output, 1 each: per-cycle strobes.
REQ-009 Port state, output, 3: current FSM state encoding.
REQ-010 Port retired, output, CNT_W: count of completed instructions.
REQ-011 Port illegal, output, 1: sticky illegal-opcode flag (trap builds only; constant 0 otherwise).

Function
REQ-012 States: FETCH=0, DECODE=1, EXECUTE=2, MEM=3, WRITEBACK=4, TRAP=5; codes 6-7 SHALL transition to FETCH.
REQ-013 Opcodes: 1 lw, 2 sw, 3 jump, 4 add, 5 addi, 6 sub; 0, 7, and any value with bits above bit 2 set SHALL be undefined.
REQ-014 FETCH: mem_read=1; stay while mem_ready=0; on mem_ready=1 pulse ir_write and pc_write, go to DECODE.
REQ-015 DECODE: latch select outputs from opcode (lw 0,1,1,0,1,0; sw 0,0,1,1,1,0; jump 0,0,0,0,0,1; add 0,1,0,0,0,0; addi 0,1,1,0,0,0; sub 1,1,0,0,0,0, in REQ-007 order); selects SHALL hold until the next DECODE.
REQ-016 DECODE, jump: pulse pc_write, increment retired, go to FETCH; other defined opcodes go to EXECUTE.
REQ-017 EXECUTE: lw/sw go to MEM; add/addi/sub go to WRITEBACK.
REQ-018 MEM: lw asserts mem_read, sw asserts mem_write; stay while mem_ready=0; on ready lw goes to WRITEBACK, sw increments retired and goes to FETCH.
REQ-019 WRITEBACK: pulse reg_write for exactly one cycle, increment retired, go to FETCH.
REQ-020 Zero-wait latency SHALL be: jump 2, add/addi/sub 4, sw 4, lw 5 cycles FETCH-to-FETCH.
REQ-021 Strobes not listed for a state SHALL be 0; mem_read and mem_write SHALL never be high together.
REQ-022 retired SHALL wrap from all-ones to 0 without any flag.
REQ-023 mem_ready arriving outside a memory-access state SHALL be ignored.

Reset
REQ-024 With reset high at a clock edge: state=FETCH, all selects and strobes 0, retired=0, illegal=0 on the following cycle.
REQ-025 Reset mid-operation, including during a memory wait, SHALL abandon the instruction without incrementing retired or issuing reg_write.
REQ-026 First post-reset cycle SHALL be FETCH with mem_read=1.

Configuration
REQ-027 Macro CTRL_ILLEGAL_TRAP_EN defined: an undefined opcode in DECODE SHALL enter TRAP, set illegal, and remain there with all strobes 0 until reset; retired unchanged.
REQ-028 Macro absent: an undefined opcode SHALL be a NOP: selects all 0, increment retired, go to FETCH (latency 2); TRAP unreachable; illegal tied 0.

Structure
REQ-029 Package ctrl_pkg SHALL hold the state enum, opcode constants, and select-vector constants.
REQ-030 Sub-module ctrl_decode (combinational opcode-to-select/legality decode) SHALL be instantiated by mc_control_fsm; the FSM, counter, and registers stay in the top.

Verification
REQ-031 add (4), mem_ready=1 always -> ir_write at cycle 1, reg_write at cycle 4 only, regSelect=1 aluSelect=0, retired 0->1.
REQ-032 lw (1), mem_ready low 3 cycles in MEM -> MEM held 4 cycles, mem_read high throughout, then one reg_write, muxSelect=1.
REQ-033 sw (2) then jump (3) -> mem_write one cycle, no reg_write; jump pc_write in DECODE, FETCH 2 cycles later, retired=2.
REQ-034 CNT_W=4, 16 add instructions -> retired wraps 15->0.
REQ-035 opcode 7: trap build -> state=5, illegal=1 held 10 cycles, retired unchanged; non-trap build -> NOP, retired+1, back to FETCH.
REQ-036 reset pulse during lw MEM wait -> next cycle FETCH, mem_read=1, retired=0, no reg_write observed.
